touch_adc_scanner: RTL and testbench

Front-end producer for the touch path: drives an XPT2046-class resistive-touch ADC over 4-wire SPI whenever the pen is down. Alternates X and Y conversions and presents each coordinate pair as a one-cycle sensor_data_ready pulse with 10-bit sensor_x/sensor_y. This is the transmitting end of the interface that the touch capture stage samples. Sits between the board pins and the capture/mapper/gesture chain.

---
 rtl/touch_adc_scanner_pkg.sv | 33 +++
 rtl/touch_adc_scanner_spi_xfer.sv | 92 +++++++++
 rtl/touch_adc_scanner.sv | 140 ++++++++++++++
 tb/tb_touch_adc_scanner.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_adc_scanner_pkg.sv
// Shared types and constants for the touch ADC scanner.
// TOUCH_ADC_AVG_EN selects 4x per-axis averaging instead of single conversions.
package touch_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER_X,
        S_XFER_Y,
        S_SETTLE,
        S_REPORT,
        S_GAP
    } state_t;

    localparam int unsigned XFER_BITS     = 24;
    localparam int unsigned RES_MSB_CYCLE = 9;
    localparam int unsigned RES_LSB_CYCLE = 20;
    localparam int unsigned SETTLE_CLKS   = 4;
    localparam int unsigned COORD_W       = 10;
    localparam int unsigned ADC_W         = 12;
    localparam int unsigned SUM_W         = 14;

    localparam logic [7:0] CMD_X_DEFAULT = 8'hD0;
    localparam logic [7:0] CMD_Y_DEFAULT = 8'h90;

`ifdef TOUCH_ADC_AVG_EN
    localparam int unsigned CONV_PER_AXIS = 4;
    localparam int unsigned COORD_LSB     = 4;
`else
    localparam int unsigned CONV_PER_AXIS = 1;
    localparam int unsigned COORD_LSB     = 2;
`endif

endpackage

// File: rtl/touch_adc_scanner_spi_xfer.sv
// One 24-SCLK SPI transaction: 8-bit command out, 12-bit result captured
// from SCLK cycles 9..20, MSB first.
module touch_spi_xfer
    import touch_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_cmd,
    output logic             o_done,
    output logic [ADC_W-1:0] o_result,
    input  logic             i_miso,
    output logic             o_sclk,
    output logic             o_mosi,
    output logic             o_cs_n
);

    // lead half + 24 high/low pairs + trail half, all with cs_n low
    localparam int unsigned HALVES = 2 * XFER_BITS + 2;

    logic             r_active;
    logic [7:0]       r_div;
    logic [5:0]       r_half;
    logic [7:0]       r_tx;
    logic [ADC_W-1:0] r_rx;
    logic [ADC_W-1:0] r_result;
    logic             r_sclk;
    logic             r_cs_n;
    logic             r_done;
    logic             w_half_end;
    logic [4:0]       w_cycle;

    assign w_half_end = (r_div == 8'(CLK_DIV - 1));
    assign w_cycle    = r_half[5:1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_half   <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_result <= '0;
            r_sclk   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_cs_n   <= 1'b0;
                    r_div    <= '0;
                    r_half   <= '0;
                    r_tx     <= i_cmd;
                    r_rx     <= '0;
                end
            end else if (w_half_end) begin
                r_div <= '0;
                if (r_half == 6'(HALVES - 1)) begin
                    r_active <= 1'b0;
                    r_cs_n   <= 1'b1;
                    r_done   <= 1'b1;
                    r_result <= r_rx;
                end else begin
                    r_half <= r_half + 6'd1;
                    if (!r_half[0] && (r_half < 6'(2 * XFER_BITS))) begin
                        // rising edge: MISO is captured on this same clk
                        r_sclk <= 1'b1;
                        if ((w_cycle >= 5'(RES_MSB_CYCLE)) && (w_cycle <= 5'(RES_LSB_CYCLE)))
                            r_rx <= {r_rx[ADC_W-2:0], i_miso};
                    end else if (r_half[0]) begin
                        r_sclk <= 1'b0;
                        r_tx   <= r_tx << 1;
                    end
                end
            end else begin
                r_div <= r_div + 8'd1;
            end
        end
    end

    // the command shifts out with zero fill, so MOSI is 0 after bit 0 and when idle
    assign o_mosi   = r_tx[7];
    assign o_sclk   = r_sclk;
    assign o_cs_n   = r_cs_n;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule

// File: rtl/touch_adc_scanner.sv
// XPT2046-class touch ADC scanner: pen-gated X/Y conversion pairs with a
// one-clk report strobe. Define TOUCH_ADC_AVG_EN for 4x per-axis averaging.
module touch_adc_scanner
    import touch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned SAMPLE_GAP = 1000,
    parameter logic [7:0]  CMD_X      = CMD_X_DEFAULT,
    parameter logic [7:0]  CMD_Y      = CMD_Y_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               pen_irq_n,
    input  logic               spi_miso,
    output logic               spi_sclk,
    output logic               spi_mosi,
    output logic               spi_cs_n,
    output logic               sensor_data_ready,
    output logic [COORD_W-1:0] sensor_x,
    output logic [COORD_W-1:0] sensor_y,
    output logic               busy
);

    localparam logic [1:0] LAST_CONV = 2'(CONV_PER_AXIS - 1);

    state_t             r_state;
    state_t             w_next;
    logic               r_pen_meta;
    logic               r_pen_sync;
    logic               w_pen_down;
    logic [31:0]        r_cnt;
    logic [1:0]         r_conv;
    logic [SUM_W-1:0]   r_sum_x;
    logic [SUM_W-1:0]   r_sum_y;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_start;
    logic [7:0]         w_cmd;
    logic               w_done;
    logic [ADC_W-1:0]   w_result;
    logic [COORD_W-1:0] w_coord_x;
    logic [COORD_W-1:0] w_coord_y;

    assign w_pen_down = ~r_pen_sync;
    assign w_coord_x  = COORD_W'(r_sum_x >> COORD_LSB);
    assign w_coord_y  = COORD_W'(r_sum_y >> COORD_LSB);

    touch_spi_xfer #(
        .CLK_DIV(CLK_DIV)
    ) u_xfer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_start (w_start),
        .i_cmd   (w_cmd),
        .o_done  (w_done),
        .o_result(w_result),
        .i_miso  (spi_miso),
        .o_sclk  (spi_sclk),
        .o_mosi  (spi_mosi),
        .o_cs_n  (spi_cs_n)
    );

    // a new transaction is started in the clk that sees done, so cs_n stays high for one clk
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_cmd   = CMD_X;
        case (r_state)
            S_IDLE: begin
                if (enable && w_pen_down) begin
                    w_next  = S_XFER_X;
                    w_start = 1'b1;
                end
            end
            S_XFER_X: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_conv == LAST_CONV) begin
                        w_next = S_XFER_Y;
                        w_cmd  = CMD_Y;
                    end
                end
            end
            S_XFER_Y: begin
                w_cmd = CMD_Y;
                if (w_done) begin
                    if (r_conv == LAST_CONV) w_next = S_SETTLE;
                    else                     w_start = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_CLKS - 1) w_next = w_pen_down ? S_REPORT : S_IDLE;
            end
            S_REPORT: w_next = S_GAP;
            S_GAP: begin
                if (r_cnt == SAMPLE_GAP - 1) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pen_meta <= 1'b1;
            r_pen_sync <= 1'b1;
            r_cnt      <= '0;
            r_conv     <= '0;
            r_sum_x    <= '0;
            r_sum_y    <= '0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_state    <= w_next;
            r_pen_meta <= pen_irq_n;
            r_pen_sync <= r_pen_meta;
            r_cnt      <= (w_next != r_state) ? '0 : r_cnt + 32'd1;
            if (w_done) r_conv <= (r_conv == LAST_CONV) ? 2'd0 : r_conv + 2'd1;
            if (r_state == S_IDLE) begin
                r_sum_x <= '0;
                r_sum_y <= '0;
            end else if (w_done && (r_state == S_XFER_X)) begin
                r_sum_x <= r_sum_x + {2'b00, w_result};
            end else if (w_done && (r_state == S_XFER_Y)) begin
                r_sum_y <= r_sum_y + {2'b00, w_result};
            end
            if ((r_state == S_SETTLE) && (w_next == S_REPORT)) begin
                r_x <= w_coord_x;
                r_y <= w_coord_y;
            end
        end
    end

    assign sensor_data_ready = (r_state == S_REPORT);
    assign sensor_x          = r_x;
    assign sensor_y          = r_y;
    assign busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_touch_adc_scanner.sv
// Scoreboard bench for touch_adc_scanner with a behavioural XPT2046 model.
// Honours TOUCH_ADC_AVG_EN to switch expected values.
module tb_touch_adc_scanner;

    localparam int unsigned CLK_DIV    = 2;
    localparam int unsigned SAMPLE_GAP = 50;
    localparam logic [7:0]  CMD_X      = 8'hD0;
    localparam logic [7:0]  CMD_Y      = 8'h90;
`ifdef TOUCH_ADC_AVG_EN
    localparam int NCONV = 4;
`else
    localparam int NCONV = 1;
`endif
    localparam int PERIOD = 1 + 2 * NCONV * (50 * CLK_DIV + 1) + 4 + 1 + SAMPLE_GAP;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       pen_irq_n;
    logic       spi_miso = 1'b0;
    logic       spi_sclk;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       sensor_data_ready;
    logic [9:0] sensor_x;
    logic [9:0] sensor_y;
    logic       busy;

    touch_adc_scanner #(
        .CLK_DIV   (CLK_DIV),
        .SAMPLE_GAP(SAMPLE_GAP),
        .CMD_X     (CMD_X),
        .CMD_Y     (CMD_Y)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .pen_irq_n        (pen_irq_n),
        .spi_miso         (spi_miso),
        .spi_sclk         (spi_sclk),
        .spi_mosi         (spi_mosi),
        .spi_cs_n         (spi_cs_n),
        .sensor_data_ready(sensor_data_ready),
        .sensor_x         (sensor_x),
        .sensor_y         (sensor_y),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
    } pair_t;

    pair_t      exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [11:0] x_vals[4];
    logic [11:0] y_vals[4];
    int         xi = 0;
    int         yi = 0;
    int         y_seen = 0;
    int         m_rise = 0;
    logic [7:0] m_cmd = '0;
    logic       m_is_x = 1'b0;
    int         pair_pos = 0;
    int         txn_in_pair = 0;
    logic       chk_period = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_vals(input logic [11:0] x0, x1, x2, x3, y0, y1, y2, y3);
        x_vals[0] = x0; x_vals[1] = x1; x_vals[2] = x2; x_vals[3] = x3;
        y_vals[0] = y0; y_vals[1] = y1; y_vals[2] = y2; y_vals[3] = y3;
    endtask

    task automatic push_exp(input logic [9:0] x, input logic [9:0] y);
        pair_t p;
        p.x = x;
        p.y = y;
        exp_q.push_back(p);
    endtask

    task automatic wait_busy(input logic lvl, input int max, input string name);
        int n = 0;
        while (busy !== lvl && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, lvl);
    endtask

    task automatic wait_sb_empty(input int max, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ADC model: shifts in the command on SCLK rise, drives MISO after SCLK fall
    initial begin
        logic       prev_cs = 1'b1;
        logic       prev_sclk = 1'b0;
        logic       prev_busy = 1'b0;
        int         t_fall = 0;
        logic [11:0] m_data = '0;
        forever begin
            @(spi_cs_n or spi_sclk or busy);
            if (!prev_busy && busy) begin
                pair_pos    = 0;
                txn_in_pair = 0;
            end
            if (prev_cs && !spi_cs_n) begin
                m_rise   = 0;
                m_cmd    = '0;
                m_is_x   = 1'b0;
                spi_miso = 1'b0;
                t_fall   = cyc;
            end else if (!prev_cs && spi_cs_n) begin
                if (reset && m_rise == 24) begin
                    check("spi_cmd", m_cmd, (pair_pos < NCONV) ? CMD_X : CMD_Y);
                    check("cs_low_clks", cyc - t_fall, 50 * CLK_DIV);
                    pair_pos++;
                    txn_in_pair++;
                end
                spi_miso = 1'b0;
            end else if (!spi_cs_n && !prev_sclk && spi_sclk) begin
                if (m_rise < 8) m_cmd = {m_cmd[6:0], spi_mosi};
                m_rise++;
                if (m_rise == 8) begin
                    m_is_x = (m_cmd == CMD_X);
                    if (m_is_x) begin
                        m_data = x_vals[xi % 4];
                        xi++;
                    end else begin
                        m_data = y_vals[yi % 4];
                        yi++;
                        y_seen++;
                    end
                end
            end else if (!spi_cs_n && prev_sclk && !spi_sclk) begin
                spi_miso = (m_rise >= 9 && m_rise <= 20) ? m_data[20 - m_rise] : 1'b0;
            end
            prev_cs   = spi_cs_n;
            prev_sclk = spi_sclk;
            prev_busy = busy;
        end
    end

    // output monitor: pops the scoreboard on every strobe
    initial begin
        logic  prev_rdy = 1'b0;
        logic  have_prev = 1'b0;
        int    last_strobe = 0;
        pair_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (sensor_data_ready) begin
                    check("strobe_width", prev_rdy, 1'b0);
                    check("txn_per_pair", txn_in_pair, 2 * NCONV);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: got x=%0h y=%0h want no strobe (cyc %0d)",
                                 sensor_x, sensor_y, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sensor_x", sensor_x, e.x);
                        check("sensor_y", sensor_y, e.y);
                    end
                    if (chk_period) begin
                        if (have_prev) check("strobe_period", cyc - last_strobe, PERIOD);
                        have_prev = 1'b1;
                    end else begin
                        have_prev = 1'b0;
                    end
                    last_strobe = cyc;
                end
                prev_rdy = sensor_data_ready;
            end else begin
                prev_rdy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        logic cs_low_seen;
        logic busy_seen;
        int   y0;
        int   n;
        reset     = 1'b0;
        enable    = 1'b1;
        pen_irq_n = 1'b1;
        set_vals(12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;

        // reset release with pen up: nothing moves
        cs_low_seen = 1'b0;
        busy_seen   = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (!spi_cs_n) cs_low_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        check("idle_cs_n", spi_cs_n, 1'b1);
        check("idle_cs_low_seen", cs_low_seen, 1'b0);
        check("idle_busy_seen", busy_seen, 1'b0);
        check("idle_sclk", spi_sclk, 1'b0);
        check("idle_mosi", spi_mosi, 1'b0);
        check("idle_ready", sensor_data_ready, 1'b0);
        check("idle_x", sensor_x, 10'h0);
        check("idle_y", sensor_y, 10'h0);

        // single pair; enable drops right after start, pair still reports
`ifdef TOUCH_ADC_AVG_EN
        set_vals(12'd100, 12'd104, 12'd108, 12'd112, 12'd400, 12'd400, 12'd400, 12'd400);
        push_exp(10'd26, 10'd100);
`else
        set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'h400, 12'h400, 12'h400, 12'h400);
        push_exp(10'h3FF, 10'h100);
`endif
        pen_irq_n = 1'b0;
        wait_busy(1'b1, 100, "pair1_start");
        enable = 1'b0;
        wait_sb_empty(3000, "pair1_report");
        wait_busy(1'b0, 500, "pair1_idle");
        busy_seen = 1'b0;
        repeat (400) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("disabled_no_restart", busy_seen, 1'b0);

        // continuous touch: three strobes at a fixed period
`ifdef TOUCH_ADC_AVG_EN
        set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'd1000, 12'd1001, 12'd1002, 12'd1003);
        repeat (3) push_exp(10'd1023, 10'd250);
`else
        set_vals(12'h804, 12'h804, 12'h804, 12'h804, 12'h3FF, 12'h3FF, 12'h3FF, 12'h3FF);
        repeat (3) push_exp(10'h201, 10'h0FF);
`endif
        chk_period = 1'b1;
        enable     = 1'b1;
        wait_sb_empty(6000, "periodic_reports");
        enable     = 1'b0;
        chk_period = 1'b0;
        wait_busy(1'b0, 500, "periodic_idle");

        // pen lifted during the Y conversion: pair discarded
        enable = 1'b1;
        wait_busy(1'b1, 100, "discard_start");
        y0 = y_seen;
        n  = 0;
        while (y_seen == y0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("discard_saw_y", (y_seen != y0), 1'b1);
        pen_irq_n = 1'b1;
        wait_busy(1'b0, 1500, "discard_idle");
`ifdef TOUCH_ADC_AVG_EN
        check("discard_hold_x", sensor_x, 10'd1023);
        check("discard_hold_y", sensor_y, 10'd250);
`else
        check("discard_hold_x", sensor_x, 10'h201);
        check("discard_hold_y", sensor_y, 10'h0FF);
`endif
        busy_seen = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
        end
        check("pen_up_no_restart", busy_seen, 1'b0);

        // reset during bit 12 of an X transaction
`ifdef TOUCH_ADC_AVG_EN
        set_vals(12'd0, 12'd1, 12'd2, 12'd3, 12'd2048, 12'd2048, 12'd2048, 12'd2048);
`else
        set_vals(12'h123, 12'h123, 12'h123, 12'h123, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
`endif
        pen_irq_n = 1'b0;
        n = 0;
        while (!(!spi_cs_n && m_is_x && m_rise == 13) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_found_bit12", (!spi_cs_n && m_is_x && m_rise == 13), 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_cs_n", spi_cs_n, 1'b1);
        check("abort_sclk", spi_sclk, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", sensor_data_ready, 1'b0);
        check("abort_x", sensor_x, 10'h0);
        @(negedge clk);
        reset = 1'b1;
`ifdef TOUCH_ADC_AVG_EN
        push_exp(10'd0, 10'd512);
`else
        push_exp(10'h048, 10'h2AF);
`endif
        wait_sb_empty(3000, "restart_report");
        enable = 1'b0;
        wait_busy(1'b0, 500, "restart_idle");

        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
